uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the UART baud tick divider (clk_div).
//  Detects the start bit and drives the divider's enable and half-period select.
//  Uses the returned ticks to sample start, data, optional parity and stop bits
//  mid-bit, then delivers a parallel byte with status flags to the core.
// PARAMETERS
//  DATA_W     8  data bits per frame, 5..9, sent LSB first
//  PARITY_EN  0  1 = one parity bit follows the data bits
//  PARITY_ODD 0  valid only when PARITY_EN=1; 0 = even parity, 1 = odd parity
// PORTS
//  clk         in   1       system clock
//  rst         in   1       reset: synchronous, active-high
//  rx          in   1       asynchronous serial line, idles at 1
//  baud_tick   in   1       one-cycle tick from the divider (its enb_cont)
//  baud_en     out  1       divider enable; low clears the divider count
//  half_bit    out  1       divider half-period select (its div_clk_en)
//  rx_data     out  DATA_W  last received word; holds its value until the next good frame
//  rx_valid    out  1       one-cycle pulse when rx_data updates
//  frame_err   out  1       one-cycle pulse: stop bit sampled as 0
//  parity_err  out  1       one-cycle pulse, in the same cycle as rx_valid: parity mismatch
//  rx_busy     out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset values
//   - All outputs reset to 0: baud_en, half_bit, rx_data, rx_valid, frame_err,
//     parity_err, rx_busy.
//   - The 2-flop rx synchronizer and its edge-history flop reset to 1.
//   - Reset in any state forces IDLE in the next cycle.
//   - A partial frame is discarded and no pulse is produced.
//  Synchronizer
//   - rx passes through 2 flops to give rx_s.
//   - A falling edge is rx_s==0 with the previous rx_s==1.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE
//    - baud_en=0, half_bit=0; baud_tick is ignored.
//    - On a falling edge: go to START with baud_en=1 and half_bit=1, registered.
//   START
//    - On baud_tick (mid start bit): if rx_s==0, go to DATA, set half_bit=0 and bit_cnt=0.
//    - Otherwise it is a false start: go to IDLE and drop baud_en.
//   DATA
//    - On each baud_tick: shift rx_s into the shift register MSB side (right shift),
//      so LSB-first arrival ends aligned at bit 0; increment bit_cnt.
//    - When bit_cnt reaches DATA_W-1 at a tick: go to PARITY if PARITY_EN, else STOP.
//   PARITY
//    - On baud_tick: latch par_bad = (^shift ^ rx_s ^ PARITY_ODD) != 0; go to STOP.
//   STOP
//    - On baud_tick with rx_s==1: rx_data<=shift, rx_valid=1, parity_err=par_bad.
//    - On baud_tick with rx_s==0: frame_err=1; rx_data is unchanged; rx_valid=0.
//    - In both cases go to IDLE with baud_en=0 in the next cycle.
//  Timing and latency
//   - The FSM leaves STOP at mid stop bit, so a back-to-back start edge is caught.
//   - Pulses assert the cycle after the stop-bit baud_tick.
//   - A falling edge in the same cycle as leaving STOP is missed.
//     The next edge-qualified low re-arms the FSM, because a line still low is
//     not an edge: no start is taken until the line returns to 1.
//   - baud_tick arriving with baud_en=0 is ignored.
//   - half_bit changes only on state transitions, never mid-count.
//  Widths
//   - bit_cnt is $clog2(DATA_W)+1 bits.
//   - Counters never wrap; a frame always ends through STOP or reset.
// TESTING
//  Bench: clk_div MAX_CNT=16 wired to baud_en/half_bit/baud_tick; rx driven at 16 clk/bit.
//  1. Send 0xA5, 8N1 -> rx_data=0xA5, rx_valid high 1 cycle, frame_err=0, rx_busy back to 0.
//  2. rx low for 4 clk, then high -> START sample=1; no rx_valid; baud_en drops; state IDLE.
//  3. Send 0x3C with stop bit=0 -> frame_err pulse, rx_valid=0, rx_data keeps the prior value.
//  4. PARITY_EN=1, even parity: 0x3C with parity 0 -> rx_valid, parity_err=0;
//     with parity 1 -> rx_valid, parity_err=1.
//  5. rst high for 1 clk after 3 data bits of 0xFF -> all outputs 0;
//     the next frame 0x5A is received correctly.
//  6. Back-to-back 0x00, 0xFF with no idle gap -> two rx_valid pulses,
//     0x00 then 0xFF, no errors.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- receive-side sequencer for a UART baud tick divider.
// Detects the start bit, runs the divider (half period first, then full bit
// periods) and samples start, data, optional parity and stop bits mid-bit.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   rx          asynchronous serial line, idles high
//   baud_tick   one-cycle tick from the divider
//   baud_en     divider enable; low clears the divider count
//   half_bit    divider half-period select
//   rx_data     last good word, held until the next good frame
//   rx_valid    one-cycle pulse when rx_data updates
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   parity_err  parity mismatch flag, valid alongside rx_valid
//   rx_busy     high whenever a frame is in progress
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | half-period wait, confirm start bit still low
// DATA   | sample DATA_W data bits, LSB first
// PARITY | sample the parity bit and record a mismatch
// STOP   | sample the stop bit, deliver the word or flag a framing error
module uart_rx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              baud_tick,
  output logic              baud_en,
  output logic              half_bit,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              rx_busy
);

  localparam int   CNT_W   = $clog2(DATA_W) + 1;
  localparam logic PAR_ODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_d;
  logic              rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic              par_bad, par_bad_d;
  logic              baud_en_d, half_bit_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_d, frame_err_d, parity_err_d;
  logic              tick, fall;

  // A tick that arrives while the divider is disabled is stale; drop it.
  assign tick    = baud_tick & baud_en;
  assign fall    = ~rx_s & rx_prev;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      baud_en    <= 1'b0;
      half_bit   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      par_bad    <= par_bad_d;
      baud_en    <= baud_en_d;
      half_bit   <= half_bit_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shift_d      = shift;
    par_bad_d    = par_bad;
    baud_en_d    = baud_en;
    half_bit_d   = half_bit;
    rx_data_d    = rx_data;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    unique case (state)
      IDLE: begin
        baud_en_d  = 1'b0;
        half_bit_d = 1'b0;
        if (fall) begin
          state_d    = START;
          baud_en_d  = 1'b1;
          half_bit_d = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          half_bit_d = 1'b0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end else begin
            state_d   = IDLE;
            baud_en_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          // Right shift: the first (LSB) bit ends up at bit 0.
          shift_d   = {rx_s, shift[DATA_W-1:1]};
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1))
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) begin
          par_bad_d = ^shift ^ rx_s ^ PAR_ODD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            rx_data_d    = shift;
            rx_valid_d   = 1'b1;
            parity_err_d = par_bad;
          end else begin
            frame_err_d = 1'b1;
          end
          // Leaving at mid stop bit leaves time to catch a back-to-back start.
          state_d   = IDLE;
          baud_en_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        baud_en_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: one 8N1 instance and one 8E1 instance, each
// driven through a behavioural 16-clock baud divider. Frames are queued as
// expected outcomes when sent and matched against the pulses the DUT emits.
module tb_uart_rx_ctrl;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx_l       [2];
  logic       baud_tick  [2];
  logic       baud_en    [2];
  logic       half_bit   [2];
  logic [7:0] rx_data    [2];
  logic       rx_valid   [2];
  logic       frame_err  [2];
  logic       parity_err [2];
  logic       rx_busy    [2];

  logic [4:0] cnt0, cnt1;
  logic [7:0] last_good [2];
  logic       pulse_d   [2];
  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       mon_e;
  int         n_tests;
  int         n_fail;

  uart_rx_ctrl #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .baud_tick(baud_tick[0]),
    .baud_en(baud_en[0]), .half_bit(half_bit[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .frame_err(frame_err[0]),
    .parity_err(parity_err[0]), .rx_busy(rx_busy[0])
  );

  uart_rx_ctrl #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .baud_tick(baud_tick[1]),
    .baud_en(baud_en[1]), .half_bit(half_bit[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .frame_err(frame_err[1]),
    .parity_err(parity_err[1]), .rx_busy(rx_busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider: 8 clocks per tick with half_bit, else 16; cleared while disabled.
  assign baud_tick[0] = baud_en[0] && (cnt0 == (half_bit[0] ? 5'd7 : 5'd15));
  assign baud_tick[1] = baud_en[1] && (cnt1 == (half_bit[1] ? 5'd7 : 5'd15));

  always @(posedge clk) begin
    if (!baud_en[0] || baud_tick[0]) cnt0 <= '0;
    else                             cnt0 <= cnt0 + 5'd1;
    if (!baud_en[1] || baud_tick[1]) cnt1 <= '0;
    else                             cnt1 <= cnt1 + 5'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (pulse_d[i])
          check("pulse_width", 32'(rx_valid[i] | frame_err[i]), 0);
        if (rx_valid[i] || frame_err[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            if (i == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            check("frame_err", 32'(frame_err[i]), 32'(mon_e.ferr));
            check("rx_valid", 32'(rx_valid[i]), 32'(!mon_e.ferr));
            if (mon_e.ferr) begin
              check("rx_data_hold", 32'(rx_data[i]), 32'(last_good[i]));
            end else begin
              check("rx_data", 32'(rx_data[i]), 32'(mon_e.data));
              check("parity_err", 32'(parity_err[i]), 32'(mon_e.perr));
              last_good[i] = mon_e.data;
            end
          end
        end else if (parity_err[i]) begin
          check("parity_err_stray", 1, 0);
        end
        pulse_d[i] = rx_valid[i] | frame_err[i];
      end
    end
  end

  task automatic drive_bit(input int w, input logic b);
    rx_l[w] = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input bit hp,
                            input bit p, input bit stop);
    exp_t e;
    e.ferr = !stop;
    e.data = d;
    e.perr = hp ? (p != ^d) : 1'b0;
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
    if (hp) drive_bit(w, p);
    drive_bit(w, stop);
    check("busy_after_frame", 32'(rx_busy[w]), 0);
    check("baud_en_after_frame", 32'(baud_en[w]), 0);
    // A low stop bit must be followed by idle, otherwise there is no edge.
    if (!stop) drive_bit(w, 1'b1);
  endtask

  task automatic check_all_zero(input int w);
    check("rst_baud_en", 32'(baud_en[w]), 0);
    check("rst_half_bit", 32'(half_bit[w]), 0);
    check("rst_rx_data", 32'(rx_data[w]), 0);
    check("rst_rx_valid", 32'(rx_valid[w]), 0);
    check("rst_frame_err", 32'(frame_err[w]), 0);
    check("rst_parity_err", 32'(parity_err[w]), 0);
    check("rst_rx_busy", 32'(rx_busy[w]), 0);
  endtask

  initial begin
    int         w;
    logic [7:0] d;
    bit         p, stop;
    int         gap;

    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    rx_l[0]      = 1'b1;
    rx_l[1]      = 1'b1;
    last_good[0] = '0;
    last_good[1] = '0;
    pulse_d[0]   = 1'b0;
    pulse_d[1]   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero(0);
    check_all_zero(1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 frame
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1);

    // False start: 4-clock glitch
    rx_l[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", 32'(rx_busy[0]), 1);
    check("glitch_baud_en", 32'(baud_en[0]), 1);
    check("glitch_half_bit", 32'(half_bit[0]), 1);
    rx_l[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle_busy", 32'(rx_busy[0]), 0);
    check("glitch_idle_baud_en", 32'(baud_en[0]), 0);
    check("glitch_idle_half_bit", 32'(half_bit[0]), 0);

    // Framing error keeps the previous word
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_data_hold", 32'(rx_data[0]), 32'hA5);

    // Even parity, good then bad
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    drive_bit(1, 1'b1);

    // Reset after three data bits of 0xFF discards the frame
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero(0);
    check_all_zero(1);
    rst          = 1'b0;
    last_good[0] = '0;
    last_good[1] = '0;
    repeat (6 * 16) @(negedge clk);
    check("post_rst_busy", 32'(rx_busy[0]), 0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames, no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b1);

    // Randomized frames on both instances
    for (int k = 0; k < 40; k++) begin
      w    = k % 2;
      d    = 8'($urandom);
      p    = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(w, d, (w == 1), p, stop);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive_bit(w, 1'b1);
    end

    repeat (48) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
